// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF    = 2'd0,
      LED_ON     = 2'd1,
      LED_BLINK  = 2'd2,
      LED_MIRROR = 2'd3
   } led_mode_e;

   // Prescaler ratio, never allowed below one so a fast tick still pulses every cycle.
   function automatic int div_f(input int clk_hz, input int tick_hz);
      int d;
      d = (tick_hz > 0) ? (clk_hz / tick_hz) : 1;
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/led_blinker_if.sv
// Control/status bundle between the board-support logic and the LED driver.
interface led_blinker_if #(
   parameter int NCH      = 8,
   parameter int PERIOD_W = 16
);
   logic [NCH-1:0][1:0]          mode_i;
   logic [NCH-1:0][PERIOD_W-1:0] half_period_i;
   logic [NCH-1:0]               key_i;
   logic                         sync_i;
   logic                         tick_o;
   logic [NCH-1:0]               led_o;

   modport master (
      output mode_i, half_period_i, key_i, sync_i,
      input  tick_o, led_o
   );

   modport slave (
      input  mode_i, half_period_i, key_i, sync_i,
      output tick_o, led_o
   );
endinterface

// File: rtl/tick_gen.sv
// Shared prescaler: one registered tick pulse every DIV sys_clk cycles.
module tick_gen #(
   parameter int DIV = 1
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic tick_o
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         cnt_q  <= '0;
         tick_o <= 1'b0;
      end else begin
         tick_o <= (cnt_q == LAST);
         cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end
endmodule

// File: rtl/led_blinker.sv
// NCH-channel LED driver: off / on / blink on a shared tick / synchronised key mirror.
module led_blinker
   import led_pkg::*;
#(
   parameter int NCH      = 8,
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int PERIOD_W = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   led_blinker_if.slave  bus
);
   localparam int DIV = div_f(CLK_HZ, TICK_HZ);

   logic tick;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .tick_o  (tick)
   );

   assign bus.tick_o = tick;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      led_mode_e           mode;
      led_mode_e           prev_mode_q;
      logic [PERIOD_W-1:0] half;
      logic [PERIOD_W-1:0] cnt_q;
      logic [1:0]          key_sync_q;
      logic                led_q;

      assign mode = led_mode_e'(bus.mode_i[i]);
      // A zero half-period would never toggle; treat it as one tick.
      assign half = (bus.half_period_i[i] == '0) ? PERIOD_W'(1) : bus.half_period_i[i];

      // NOTE: reset is synchronous, so it is only honoured inside the clocked branch.
      always_ff @(posedge sys_clk) begin
         if (!sys_rst) begin
            cnt_q       <= '0;
            led_q       <= 1'b0;
            key_sync_q  <= '0;
            prev_mode_q <= LED_OFF;
         end else begin
            key_sync_q  <= {key_sync_q[0], bus.key_i[i]};
            prev_mode_q <= mode;
            unique case (mode)
               LED_OFF: begin
                  led_q <= 1'b0;
                  cnt_q <= '0;
               end
               LED_ON: begin
                  led_q <= 1'b1;
                  cnt_q <= '0;
               end
               LED_MIRROR: begin
                  led_q <= key_sync_q[1];
                  cnt_q <= '0;
               end
               LED_BLINK: begin
                  if (bus.sync_i || prev_mode_q != LED_BLINK) begin
                     led_q <= 1'b1;
                     cnt_q <= '0;
                  end else if (tick) begin
                     // >= lets a freshly lowered half-period take effect on the next tick.
                     if (cnt_q >= half - PERIOD_W'(1)) begin
                        led_q <= ~led_q;
                        cnt_q <= '0;
                     end else begin
                        cnt_q <= cnt_q + PERIOD_W'(1);
                     end
                  end
               end
               default: begin
                  led_q <= 1'b0;
                  cnt_q <= '0;
               end
            endcase
         end
      end

      assign bus.led_o[i] = led_q;
   end
endmodule
